bit_reducer_stream: RTL

Streaming, runtime-configurable bit reducer. It folds every bit of a multi-word frame into a single result bit, using one of AND/NAND/OR/NOR/XOR/XNOR selected at frame start. Per-bit masking excludes bits from the reduction. It sits between a valid/ready word source (e.g. a status-flag or parity collector) and a single-bit consumer, and replaces fixed-width, fixed-operation combinational reduction wherever data arrives over several cycles.

---
 rtl/bit_reducer_stream_if.sv | 29 ++
 rtl/bit_reducer_stream.sv | 131 +++++++++++++
 2 files changed

// File: rtl/bit_reducer_stream_if.sv
// Word-stream and result handshake bundle for bit_reducer_stream.
// The slave modport is the reducer's view; the master modport is the source/consumer side.
interface bit_reducer_stream_if #(
    parameter int WORD_WIDTH  = 8,
    parameter int COUNT_WIDTH = 8
);
    logic [2:0]             op_select;
    logic                   in_valid;
    logic                   in_ready;
    logic [WORD_WIDTH-1:0]  in_data;
    logic [WORD_WIDTH-1:0]  in_mask;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_bit;
    logic [COUNT_WIDTH-1:0] out_count;
    logic                   out_empty;
    logic                   out_op_error;

    modport slave (
        input  op_select, in_valid, in_data, in_mask, in_last, out_ready,
        output in_ready, out_valid, out_bit, out_count, out_empty, out_op_error
    );

    modport master (
        output op_select, in_valid, in_data, in_mask, in_last, out_ready,
        input  in_ready, out_valid, out_bit, out_count, out_empty, out_op_error
    );
endinterface

// File: rtl/bit_reducer_stream.sv
// Folds every unmasked bit of a multi-word frame into one result bit using an
// AND/NAND/OR/NOR/XOR/XNOR operation chosen on the frame's first word.
module bit_reducer_stream #(
    parameter int WORD_WIDTH  = 8,
    parameter int COUNT_WIDTH = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    bit_reducer_stream_if.slave bus
);
    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_NAND = 3'd1,
        OP_OR   = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5
    } op_e;

    state_t                 state_q;
    op_e                    op_q;
    logic                   acc_q;
    logic [COUNT_WIDTH-1:0] cnt_q;
    logic                   empty_q;
    logic                   out_valid_q;
    logic                   out_bit_q;
    logic [COUNT_WIDTH-1:0] out_count_q;
    logic                   out_empty_q;
    logic                   out_op_error_q;

    logic                   in_ready;
    logic                   accept;
    logic                   first;
    op_e                    op_cur;
    logic                   acc_base;
    logic                   acc_d;
    logic [COUNT_WIDTH-1:0] cnt_d;
    logic                   empty_d;
    logic                   invert;
    logic                   valid_op;
    logic                   result_d;

    // A held result blocks every word, so a frame can never complete into an occupied register.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign first    = (state_q == IDLE);

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        op_cur   = first ? op_e'(bus.op_select) : op_q;
        acc_base = 1'b0;
        acc_d    = 1'b0;
        invert   = 1'b0;
        valid_op = 1'b1;
        case (op_cur)
            OP_AND, OP_NAND: begin
                acc_base = first ? 1'b1 : acc_q;
                acc_d    = acc_base & (&(bus.in_data | ~bus.in_mask));
                invert   = (op_cur == OP_NAND);
            end
            OP_OR, OP_NOR: begin
                acc_base = first ? 1'b0 : acc_q;
                acc_d    = acc_base | (|(bus.in_data & bus.in_mask));
                invert   = (op_cur == OP_NOR);
            end
            OP_XOR, OP_XNOR: begin
                acc_base = first ? 1'b0 : acc_q;
                acc_d    = acc_base ^ (^(bus.in_data & bus.in_mask));
                invert   = (op_cur == OP_XNOR);
            end
            default: valid_op = 1'b0;
        endcase

        result_d = valid_op && (acc_d ^ invert);

        if (first) begin
            cnt_d   = COUNT_WIDTH'(1);
            empty_d = ~|bus.in_mask;
        end else begin
            cnt_d   = (&cnt_q) ? cnt_q : cnt_q + COUNT_WIDTH'(1);
            empty_d = empty_q && ~|bus.in_mask;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            op_q           <= OP_AND;
            acc_q          <= 1'b0;
            cnt_q          <= '0;
            empty_q        <= 1'b0;
            out_valid_q    <= 1'b0;
            out_bit_q      <= 1'b0;
            out_count_q    <= '0;
            out_empty_q    <= 1'b0;
            out_op_error_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= op_cur;
                acc_q   <= acc_d;
                cnt_q   <= cnt_d;
                empty_q <= empty_d;
                state_q <= bus.in_last ? IDLE : ACCUM;
            end

            // Completing a frame wins over a pop, so a same-cycle pop and reload keeps out_valid high.
            if (accept && bus.in_last) begin
                out_valid_q    <= 1'b1;
                out_bit_q      <= result_d;
                out_count_q    <= cnt_d;
                out_empty_q    <= empty_d;
                out_op_error_q <= !valid_op;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_bit      = out_bit_q;
    assign bus.out_count    = out_count_q;
    assign bus.out_empty    = out_empty_q;
    assign bus.out_op_error = out_op_error_q;
endmodule
